// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory byte-stream loader.
// Holds the loader state encoding and the number of stream bytes that
// make up one instruction word.
package imem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_BYTE  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader.sv
// imem_loader
// Receives a program image as a valid/ready byte stream and writes it,
// one word per write cycle, into a write-enabled instruction memory while
// holding the core off.
// Stream format: one header byte N (word count, 1..REGSIZE), then N words
// of four bytes each, little-endian (first byte lands in bits [7:0]).
// Optional feature macro IMEM_LOADER_CHECKSUM_EN: one trailing byte must
// equal the XOR of all data bytes, otherwise the load ends in error.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle load request (honoured in IDLE, DONE, ERR)
//   in_data      stream byte
//   in_valid     in_data valid
//   in_ready     loader accepts a byte this cycle (HDR, BYTE, CHK)
//   mem_we       instruction memory write strobe (one cycle per word)
//   mem_addr     word index written, 0..N-1
//   mem_wdata    assembled instruction word
//   busy         load in progress
//   done         load complete
//   err          load failed (bad header or checksum mismatch)
//   cpu_hold     core held off; low only once the load has completed
//   words_loaded number of words written in the current load
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned BITSIZE = 32,
    parameter int unsigned REGSIZE = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [REGSIZE-1:0] mem_addr,
    output logic [BITSIZE-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               cpu_hold,
    output logic [5:0]         words_loaded
);

    state_t             state_q;
    logic [BITSIZE-1:0] word_q;
    logic [1:0]         byte_idx_q;
    logic [7:0]         n_q;
    logic [5:0]         words_loaded_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q;
`endif

    logic       xfer;
    logic [7:0] words_next;

    assign xfer       = in_valid && in_ready;
    assign words_next = {2'b00, words_loaded_q} + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Partial word and byte position are dropped so nothing
            // half-assembled can ever reach the memory.
            state_q        <= ST_IDLE;
            word_q         <= '0;
            byte_idx_q     <= '0;
            n_q            <= '0;
            words_loaded_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        words_loaded_q <= '0;
                        state_q        <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        byte_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                        if (in_data == 8'd0 || 32'(in_data) > REGSIZE) begin
                            state_q <= ST_ERR;
                        end else begin
                            n_q     <= in_data;
                            state_q <= ST_BYTE;
                        end
                    end
                end
                ST_BYTE: begin
                    if (xfer) begin
                        word_q[{byte_idx_q, 3'b000} +: 8] <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ in_data;
`endif
                        if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
                            byte_idx_q <= '0;
                            state_q    <= ST_WRITE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    // words_loaded_q is this word's index during WRITE;
                    // it becomes the count of written words afterwards.
                    words_loaded_q <= words_next[5:0];
                    if (words_next < n_q) begin
                        state_q <= ST_BYTE;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q <= ST_CHK;
`else
                        state_q <= ST_DONE;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (xfer) begin
                        state_q <= (in_data == csum_q) ? ST_DONE : ST_ERR;
                    end
                end
`endif
                ST_DONE, ST_ERR: begin
                    if (start) begin
                        words_loaded_q <= '0;
                        state_q        <= ST_HDR;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of the state register, so they change only
    // on the clock edge and fall to their reset values with the state.
    assign in_ready     = (state_q == ST_HDR) || (state_q == ST_BYTE) ||
                          (state_q == ST_CHK);
    assign mem_we       = (state_q == ST_WRITE);
    assign mem_addr     = mem_we ? REGSIZE'(words_loaded_q) : '0;
    assign mem_wdata    = mem_we ? word_q : '0;
    assign busy         = (state_q == ST_HDR) || (state_q == ST_BYTE) ||
                          (state_q == ST_WRITE) || (state_q == ST_CHK);
    assign done         = (state_q == ST_DONE);
    assign err          = (state_q == ST_ERR);
    assign cpu_hold     = (state_q != ST_DONE);
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized
// loads, each compared with expectations derived from the stream format.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done, err, cpu_hold;
    logic [5:0]  words_loaded;

    int total = 0;
    int bad   = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          idle_leak = 0;

    always #5 clk = ~clk;

    imem_loader #(.BITSIZE(32), .REGSIZE(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cpu_hold     (cpu_hold),
        .words_loaded (words_loaded)
    );

    // Write capture: one entry per cycle with mem_we high, so a strobe
    // longer than one cycle shows up as extra writes.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end else if (mem_addr != 32'd0 || mem_wdata != 32'd0) begin
            idle_leak++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called and returns at a falling edge; idles for gap cycles, then
    // offers the byte until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
        if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_end();
        for (int t = 0; t < 300 && !(done || err); t++) @(negedge clk);
        check("end_timeout", 64'(done | err), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_mem_we"},   64'(mem_we),   64'd0);
        check({tag, "_addr"},     64'(mem_addr), 64'd0);
        check({tag, "_wdata"},    64'(mem_wdata), 64'd0);
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_done"},     64'(done),     64'd0);
        check({tag, "_err"},      64'(err),      64'd0);
        check({tag, "_hold"},     64'(cpu_hold), 64'd1);
        check({tag, "_wl"},       64'(words_loaded), 64'd0);
    endtask

    // One complete load. Expected outcome comes from the stream rules:
    // header must be 1..32, words are little-endian groups of 4 bytes,
    // and (with checksum) the trailer must equal the XOR of data bytes.
    // csum_sel < 0 sends the correct trailer, otherwise sends csum_sel.
    task automatic run_load(input string tag, input logic [7:0] n, input logic [7:0] data[$],
                            input int gapmax, input int gap_at, input int csum_sel);
        int          nw;
        bit          exp_ok;
        logic [31:0] w;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0]  x;
        logic [7:0]  sent;
`endif
        wr_addr_q.delete();
        wr_data_q.delete();
        nw = (n >= 8'd1 && n <= 8'd32) ? int'(n) : 0;
        pulse_start();
        send_byte(n, $urandom_range(0, gapmax));
        for (int i = 0; i < nw * 4; i++)
            send_byte(data[i], (i == gap_at) ? 3 : $urandom_range(0, gapmax));
        exp_ok = (nw != 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (nw != 0) begin
            x = 8'd0;
            for (int i = 0; i < nw * 4; i++) x = x ^ data[i];
            sent = (csum_sel < 0) ? x : 8'(csum_sel);
            send_byte(sent, $urandom_range(0, gapmax));
            exp_ok = (sent == x);
        end
`endif
        wait_end();
        $display("load %s n=%0d csum_sel=%0d expect_ok=%0b done=%0b err=%0b writes=%0d",
                 tag, n, csum_sel, exp_ok, done, err, wr_addr_q.size());
        check({tag, "_done"},   64'(done),     64'(exp_ok));
        check({tag, "_err"},    64'(err),      64'(!exp_ok));
        check({tag, "_hold"},   64'(cpu_hold), 64'(!exp_ok));
        check({tag, "_busy"},   64'(busy),     64'd0);
        check({tag, "_wl"},     64'(words_loaded), 64'(nw));
        check({tag, "_nwr"},    64'(wr_addr_q.size()), 64'(nw));
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            w = {data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]};
            check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_q[i]), 64'(i));
            check($sformatf("%s_data%0d", tag, i), 64'(wr_data_q[i]), 64'(w));
        end
    endtask

    initial begin
        logic [7:0] d[$];
        logic [7:0] nrand;

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        // Single word 0x0010009F.
        d = '{8'h9F, 8'h00, 8'h10, 8'h00};
        run_load("single", 8'd1, d, 0, -1, -1);

        // Two words with a 3-cycle valid gap inside the first word.
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
        run_load("gap", 8'd2, d, 0, 2, -1);

        // Header boundaries.
        d.delete();
        run_load("hdr00", 8'd0, d, 0, -1, -1);
        run_load("hdr21", 8'h21, d, 0, -1, -1);

        // Reset after the second data byte, then a fresh load.
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'd1, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("postrst");
        check("midrst_nwr", 64'(wr_addr_q.size()), 64'd0);
        d = '{8'h78, 8'h56, 8'h34, 8'h12};
        run_load("fresh", 8'd1, d, 1, -1, -1);

        // Start pulsed in the middle of a word must be ignored.
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'd1, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        pulse_start();
        check("midstart_busy", 64'(busy), 64'd1);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h04, 0);
`endif
        wait_end();
        $display("load midstart done=%0b writes=%0d", done, wr_addr_q.size());
        check("midstart_done", 64'(done), 64'd1);
        check("midstart_nwr",  64'(wr_addr_q.size()), 64'd1);
        if (wr_data_q.size() > 0)
            check("midstart_data", 64'(wr_data_q[0]), 64'h04030201);

        // Full-depth load: last index written is 31.
        d.delete();
        for (int i = 0; i < 128; i++) d.push_back(8'($urandom));
        run_load("full32", 8'd32, d, 0, -1, -1);

        // Randomized loads with random gaps, occasionally a bad header.
        for (int k = 0; k < 8; k++) begin
            nrand = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(33, 255))
                                                : 8'($urandom_range(1, 10));
            d.delete();
            for (int i = 0; i < 4 * int'(nrand); i++) d.push_back(8'($urandom));
            run_load($sformatf("rand%0d", k), nrand, d, 2, -1, -1);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        d = '{8'h9F, 8'h00, 8'h10, 8'h00};
        run_load("csum8f", 8'd1, d, 0, -1, 8'h8F);
        run_load("csum00", 8'd1, d, 0, -1, 8'h00);
        d.delete();
        for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
        run_load("csumbad", 8'd3, d, 1, -1, 256 + $urandom_range(0, 255));
`endif

        check("idle_outputs_zero", 64'(idle_leak), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
